// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: multi-cycle WIDTHxWIDTH multiplier (unsigned add-shift / signed radix-2 Booth)
// driving an external shared ripple adder; one iteration per clock, product registered in DONE.
module alu_seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_signed,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_en,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
    logic               q1_q, q1_d, mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               run, do_add, do_sub, top;
    logic [WIDTH-1:0]   beff;

    always_comb begin
        run    = state_q == RUN;
        do_add = mode_q ? (~q_q[0] & q1_q) : q_q[0];
        do_sub = mode_q & q_q[0] & ~q1_q;
        add_a  = run ? a_q : '0;
        add_b  = (run & (do_add | do_sub)) ? m_q : '0;
        add_en = run & do_sub;
        beff   = add_en ? ~add_b : add_b;
        // true sign of the WIDTH+1-bit sum, so M = -2^(WIDTH-1) cannot overflow
        top    = mode_q ? (a_q[WIDTH-1] ^ beff[WIDTH-1] ^ add_cout) : add_cout;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        q1_d        = q1_q;
        m_d         = m_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        prod_d      = prod_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = RUN;
                m_d     = req_a;
                q_d     = req_b;
                mode_d  = req_signed;
                a_d     = '0;
                q1_d    = 1'b0;
                cnt_d   = '0;
            end
            RUN: begin
                {a_d, q_d, q1_d} = {top, add_sum, q_q};
                cnt_d            = cnt_q + CNT_W'(1);
                state_d          = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : RUN;
            end
            DONE: if (!res_valid_q) begin
                res_valid_d = 1'b1;
                prod_d      = {a_q, q_q};
            end else if (res_ready) begin
                res_valid_d = 1'b0;
                prod_d      = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            m_q         <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            q1_q        <= q1_d;
            m_q         <= m_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            prod_q      <= prod_d;
        end
    end

    assign req_ready   = state_q == IDLE;
    assign res_valid   = res_valid_q;
    assign res_product = prod_q;
endmodule

// File: tb/tb_alu_seq_multiplier.sv
// tb_alu_seq_multiplier: directed checks of the sequential multiplier with a behavioural
// model of the shared ripple adder closing the add_* loop.
module tb_alu_seq_multiplier;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_signed = 1'b0;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [2*W-1:0] res_product;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_en, add_cout;

    int n_checks = 0;
    int n_fail = 0;

    alu_seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .add_a(add_a), .add_b(add_b), .add_en(add_en),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // shared adder: subtract inverts operand b and forces carry-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_en ? ~add_b : add_b} + 33'(add_en);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // present a request for one accepting edge; returns at the negedge after it
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_a = a;
        req_b = b;
        req_signed = s;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_product !== '0 ||
            add_a !== '0 || add_b !== '0 || add_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b prod=%h a=%h b=%h en=%b",
                     req_ready, res_valid, res_product, add_a, add_b, add_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b want 1/0", req_ready, res_valid);
        end
    endtask

    task automatic test_unsigned_small();
        logic [W-1:0] b = 32'd5;
        issue(32'd3, b, 1'b0);
        for (int i = 0; i < 33; i++) begin
            if (i < 32) begin
                n_checks++;
                if (add_en !== 1'b0 || add_b !== (b[i] ? 32'd3 : 32'd0)) begin
                    n_fail++;
                    $display("FAIL u3x5_drive it%0d: en=%b b=%h", i, add_en, add_b);
                end
            end
            n_checks++;
            if (res_valid !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL u3x5_early it%0d: vld=%b rdy=%b want 0/0", i, res_valid, req_ready);
            end
            step();
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_product !== 64'h0000_0000_0000_000F) begin
            n_fail++;
            $display("FAIL u3x5_result: vld=%b prod=%h want 1/000000000000000f", res_valid, res_product);
        end
        step();
        n_checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL u3x5_handshake: vld=%b rdy=%b want 0/1", res_valid, req_ready);
        end
    endtask

    task automatic test_unsigned_max();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 33; i++) begin
            if (i < 32) begin
                n_checks++;
                if (add_en !== 1'b0 || add_b !== 32'hFFFF_FFFF) begin
                    n_fail++;
                    $display("FAIL umax_drive it%0d: en=%b b=%h", i, add_en, add_b);
                end
            end
            step();
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_product !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL umax_result: vld=%b prod=%h want 1/fffffffe00000001", res_valid, res_product);
        end
        step();
    endtask

    task automatic test_signed();
        logic [W-1:0]   va [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0]   vb [3] = '{32'd5, 32'h8000_0000, 32'd1};
        logic [2*W-1:0] vp [3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000,
                                   64'hFFFF_FFFF_8000_0000};
        for (int v = 0; v < 3; v++) begin
            logic [W-1:0] b;
            logic         prev;
            b = vb[v];
            prev = 1'b0;
            issue(va[v], b, 1'b1);
            for (int i = 0; i < 33; i++) begin
                if (i < 32) begin
                    n_checks++;
                    if (add_en !== (b[i] & ~prev) || add_b !== ((b[i] ^ prev) ? va[v] : 32'd0)) begin
                        n_fail++;
                        $display("FAIL signed%0d_drive it%0d: en=%b b=%h want en=%b",
                                 v, i, add_en, add_b, b[i] & ~prev);
                    end
                    prev = b[i];
                end
                step();
            end
            n_checks++;
            if (res_valid !== 1'b1 || res_product !== vp[v]) begin
                n_fail++;
                $display("FAIL signed%0d_result: vld=%b prod=%h want %h", v, res_valid, res_product, vp[v]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        issue(32'd12, 32'd10, 1'b0);
        for (int i = 0; i < 33; i++) step();
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_product !== 64'h78 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: vld=%b prod=%h rdy=%b want 1/78/0",
                         k, res_valid, res_product, req_ready);
            end
            if (k == 3) begin
                req_a = 32'h55;
                req_b = 32'h66;
                req_valid = 1'b1;
            end
            step();
            req_valid = 1'b0;
        end
        res_ready = 1'b1;
        step();
        n_checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0/1", res_valid, req_ready);
        end
        issue(32'd2, 32'd3, 1'b0);
        for (int i = 0; i < 33; i++) step();
        n_checks++;
        if (res_valid !== 1'b1 || res_product !== 64'd6) begin
            n_fail++;
            $display("FAIL bp_next: vld=%b prod=%h want 1/6", res_valid, res_product);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 17; i++) step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_product !== '0 ||
            add_a !== '0 || add_b !== '0 || add_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b vld=%b prod=%h a=%h b=%h en=%b",
                     req_ready, res_valid, res_product, add_a, add_b, add_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd7, 32'd6, 1'b0);
        for (int i = 0; i < 32; i++) step();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL postreset_early: vld=%b want 0", res_valid);
        end
        step();
        n_checks++;
        if (res_valid !== 1'b1 || res_product !== 64'h2A) begin
            n_fail++;
            $display("FAIL postreset_result: vld=%b prod=%h want 1/2a", res_valid, res_product);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_unsigned_small();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_multiplier.md
Name: alu_seq_multiplier

Overview:
- Area-oriented multi-cycle 32x32->64 multiplier for the area-optimised ALU.
- Owns no adder of its own. It drives the shared 32-bit ripple adder's operand and subtract-enable inputs and consumes its sum and carry-out every iteration, so it sits both directly upstream and directly downstream of that adder.
- Supports unsigned add-shift and signed radix-2 Booth modes, with valid/ready handshakes on request and result.

Parameters:
- WIDTH, 32: operand width. Must equal the shared adder width; product is 2*WIDTH.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request operands valid
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_signed  input  1  1 = signed Booth mode, 0 = unsigned add-shift mode
- req_a  input  WIDTH  multiplicand M
- req_b  input  WIDTH  multiplier Q
- res_valid  output  1  product valid
- res_ready  input  1  consumer accepts product
- res_product  output  2*WIDTH  product
- add_a  output  WIDTH  to adder_in0
- add_b  output  WIDTH  to adder_in1 (un-inverted; the adder inverts when add_en=1)
- add_en  output  1  to adder en (1 = subtract: inverts add_b and forces carry-in 1)
- add_sum  input  WIDTH  from adder_out
- add_cout  input  1  from carry_out

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; A, Q, q_1, M, counter and mode clear to 0.
  - req_ready=1, res_valid=0, res_product=0, add_a=0, add_b=0, add_en=0.
- States: IDLE, RUN, DONE. Transitions:
  - IDLE->RUN on req_valid & req_ready.
  - RUN->DONE when the counter reaches WIDTH-1 and that step completes.
  - DONE->IDLE on res_valid & res_ready.
- Accept (IDLE, req_valid=1): latch M=req_a, Q=req_b, mode=req_signed; set A=0, q_1=0, counter=0.
- Adder drive in RUN (purely combinational from registers):
  - add_a = A.
  - Unsigned: Q[0]=1 -> add_b=M, add_en=0; otherwise add_b=0, add_en=0.
  - Signed, {Q[0],q_1}:
    - 01 -> add_b=M, add_en=0
    - 10 -> add_b=M, add_en=1
    - 00 or 11 -> add_b=0, add_en=0
- Adder drive outside RUN: add_a=0, add_b=0, add_en=0.
- Per RUN cycle update, where beff = add_en ? ~add_b : add_b:
  - Top bit t: unsigned t = add_cout; signed t = A[WIDTH-1] ^ beff[WIDTH-1] ^ add_cout. This is the true sign of the WIDTH+1-bit result and prevents overflow at M = -2^(WIDTH-1).
  - Shift: {A, Q, q_1} <= {t, add_sum, Q}, discarding the old q_1.
  - Counter increments by 1.
- Exactly WIDTH RUN cycles.
  - res_valid rises WIDTH+1 clocks after the accepting edge, and res_product = {A, Q} is registered.
  - Zero operands and all-ones operands take the same latency; there is no early exit.
- DONE:
  - res_valid=1 and res_product held stable until res_ready.
  - res_ready may be tied high; DONE then lasts exactly 1 cycle.
- req_ready=0 in RUN and DONE; req_valid there is ignored and operands are not latched.
- The next request can be accepted on the cycle after the DONE->IDLE handshake.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values. No partial product is ever presented.
- Adder is a combinational path through add_* ports. The full-chain ripple delay is in this block's cycle.

Test Plan:
- Unsigned 3 x 5: req_signed=0 -> res_valid at accept+33, res_product=0x0000_0000_0000_000F.
- Unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> res_product=0xFFFF_FFFE_0000_0001; check add_en=0 in every RUN cycle.
- Signed cases, req_signed=1:
  - -3 x 5 (0xFFFF_FFFD x 5) -> 0xFFFF_FFFF_FFFF_FFF1; add_en=1 on the iterations where {Q0,q_1}=10.
  - 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000, exercising the sign-correction bit.
  - 0x8000_0000 x 1 -> 0xFFFF_FFFF_8000_0000.
- Backpressure:
  - res_ready=0 for 10 cycles after res_valid -> product and res_valid held, req_ready=0.
  - A req_valid pulse with different operands during that window is ignored.
  - After the handshake, req_ready=1 the next cycle.
- Reset: rst_n low at RUN iteration 17 -> outputs reset asynchronously. After release, a new 7 x 6 unsigned request -> 0x2A at accept+33.
